// File: rtl/bus_sampler.sv
// Socket-side front end for the 6530 core: oversamples the asynchronous 6502 bus,
// latches one clean transaction per PHI2 cycle and drives read data back onto the socket.
module bus_sampler #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 3,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bus_phi2,
   input  logic       bus_rw,
   input  logic [9:0] bus_addr,
   input  logic       bus_cs1,
   input  logic       bus_rs0,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   output logic       core_phi2,
   output logic       core_we_n,
   output logic [9:0] core_A,
   output logic       core_CS1,
   output logic       core_RS0,
   output logic [7:0] core_DI,
   input  logic [7:0] core_DO,
   input  logic       core_OE
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      READ   = 3'd2,
      WRITE  = 3'd3,
      PULSE  = 3'd4,
      HOLD   = 3'd5
   } state_t;

   // PHI2 synchroniser chain
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   phi2_s;
   logic                   phi2_d_q;
   logic                   armed_q, armed_d;
   logic                   rise, fall;

   assign sync_d[0] = bus_phi2;
   assign fill_d[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign sync_d[gi] = sync_q[gi-1];
         assign fill_d[gi] = fill_q[gi-1];
      end
   endgenerate

   assign phi2_s = sync_q[SYNC_STAGES-1];
   assign rise   = phi2_s & ~phi2_d_q;
   assign fall   = ~phi2_s & phi2_d_q;

   // A rise only counts once PHI2 has been seen low through a fully refilled chain,
   // so a cycle cut short by reset cannot produce a pulse when its fall arrives.
   assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~phi2_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         fill_q   <= '0;
         phi2_d_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         fill_q   <= fill_d;
         phi2_d_q <= phi2_s;
         armed_q  <= armed_d;
      end
   end

   // Transaction FSM
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             core_phi2_q, core_phi2_d;
   logic             we_n_q, we_n_d;
   logic [9:0]       addr_q, addr_d;
   logic             cs1_q, cs1_d;
   logic             rs0_q, rs0_d;
   logic [7:0]       di_q, di_d;
   logic [7:0]       dout_q, dout_d;
   logic             oe_q, oe_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         core_phi2_q <= 1'b0;
         we_n_q      <= 1'b1;
         addr_q      <= '0;
         cs1_q       <= 1'b0;
         rs0_q       <= 1'b0;
         di_q        <= '0;
         dout_q      <= '0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         core_phi2_q <= core_phi2_d;
         we_n_q      <= we_n_d;
         addr_q      <= addr_d;
         cs1_q       <= cs1_d;
         rs0_q       <= rs0_d;
         di_q        <= di_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_n_d  = we_n_q;
      addr_d  = addr_q;
      cs1_d   = cs1_q;
      rs0_d   = rs0_q;
      di_d    = di_q;
      dout_d  = dout_q;
      oe_d    = oe_q;

      case (state_q)
         IDLE: begin
            if (rise && armed_q) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end

         SETTLE: begin
            if (fall) begin
               // Cycle ended before the latch: hand the core a deselected, read-only cycle.
               cs1_d   = 1'b0;
               rs0_d   = 1'b0;
               we_n_d  = 1'b1;
               state_d = PULSE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == SETTLE_LAST) begin
                  addr_d  = bus_addr;
                  we_n_d  = bus_rw;
                  cs1_d   = bus_cs1;
                  rs0_d   = bus_rs0;
                  state_d = bus_rw ? READ : WRITE;
                  if (!bus_rw) begin
                     oe_d = 1'b0;
                  end
               end
            end
         end

         READ: begin
            dout_d = core_DO;
            oe_d   = core_OE;
            if (fall) begin
               state_d = PULSE;
            end
         end

         WRITE: begin
            oe_d = 1'b0;
            if (fall) begin
               di_d    = bus_data_in;
               state_d = PULSE;
            end
         end

         PULSE: begin
            cnt_d = '0;
            if (rise) begin
               oe_d    = 1'b0;
               we_n_d  = 1'b1;
               state_d = SETTLE;
            end else begin
               state_d = HOLD;
               if (HOLD_CYCLES == 0) begin
                  oe_d = 1'b0;
               end
            end
         end

         HOLD: begin
            if (rise) begin
               oe_d    = 1'b0;
               we_n_d  = 1'b1;
               cnt_d   = '0;
               state_d = SETTLE;
            end else if (cnt_q == HOLD_LAST) begin
               oe_d    = 1'b0;
               we_n_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // PULSE never lasts more than one cycle, so entering it is the whole pulse.
      core_phi2_d = (state_d == PULSE);
   end

   assign bus_data_out = dout_q;
   assign bus_data_oe  = oe_q;
   assign core_phi2    = core_phi2_q;
   assign core_we_n    = we_n_q;
   assign core_A       = addr_q;
   assign core_CS1     = cs1_q;
   assign core_RS0     = rs0_q;
   assign core_DI      = di_q;

endmodule

// File: tb/tb_bus_sampler.sv
// Bench for bus_sampler: table of bus cycles checked through a pulse scoreboard,
// plus hand-timed sequences for latch latency, reset behaviour and aborted cycles.
module tb_bus_sampler;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_phi2, bus_rw, bus_cs1, bus_rs0;
   logic [9:0] bus_addr;
   logic [7:0] bus_data_in, bus_data_out;
   logic       bus_data_oe, core_phi2, core_we_n, core_CS1, core_RS0, core_OE;
   logic [9:0] core_A;
   logic [7:0] core_DI, core_DO;

   always #5 clk = ~clk;

   bus_sampler dut (
      .clk(clk), .rst(rst),
      .bus_phi2(bus_phi2), .bus_rw(bus_rw), .bus_addr(bus_addr),
      .bus_cs1(bus_cs1), .bus_rs0(bus_rs0), .bus_data_in(bus_data_in),
      .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
      .core_phi2(core_phi2), .core_we_n(core_we_n), .core_A(core_A),
      .core_CS1(core_CS1), .core_RS0(core_RS0), .core_DI(core_DI),
      .core_DO(core_DO), .core_OE(core_OE)
   );

   typedef struct {
      logic       rw;
      logic [9:0] addr;
      logic       cs1, rs0;
      logic [7:0] din, cdo;
      logic       coe;
      int         high, low;
      logic       exp_we_n;
      logic [9:0] exp_a;
      logic       exp_cs1, exp_rs0;
      logic [7:0] exp_di, exp_dout;
      logic       exp_oe;
      logic       chk_a, chk_di, chk_dout;
   } vec_t;

   typedef struct {
      logic       we_n;
      logic [9:0] a;
      logic       cs1, rs0;
      logic [7:0] di, dout;
      logic       oe;
      logic       chk_a, chk_di, chk_dout;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   pushed = 0;
   logic phi2_prev = 1'b0;
   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(input vec_t v);
      exp_t e;
      e.we_n = v.exp_we_n; e.a = v.exp_a; e.cs1 = v.exp_cs1; e.rs0 = v.exp_rs0;
      e.di = v.exp_di; e.dout = v.exp_dout; e.oe = v.exp_oe;
      e.chk_a = v.chk_a; e.chk_di = v.chk_di; e.chk_dout = v.chk_dout;
      return e;
   endfunction

   // Pulse monitor: every core_phi2 pulse must match the oldest outstanding bus cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("oe_while_write", {31'd0, bus_data_oe & ~core_we_n}, 32'd0);
         if (core_phi2) begin
            pulses++;
            if (phi2_prev) begin
               checks++; errors++;
               $display("FAIL pulse_width: core_phi2 high for more than one clk at %0t", $time);
            end
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pulse: got a core_phi2 pulse, required none at %0t", $time);
            end else begin
               mon_e = sb_q.pop_front();
               $display("pulse %0d: A=%h we_n=%b cs1=%b rs0=%b DI=%h dout=%h oe=%b", pulses,
                        core_A, core_we_n, core_CS1, core_RS0, core_DI, bus_data_out, bus_data_oe);
               chk("pulse_we_n", {31'd0, core_we_n}, {31'd0, mon_e.we_n});
               chk("pulse_cs1", {31'd0, core_CS1}, {31'd0, mon_e.cs1});
               chk("pulse_rs0", {31'd0, core_RS0}, {31'd0, mon_e.rs0});
               chk("pulse_oe", {31'd0, bus_data_oe}, {31'd0, mon_e.oe});
               if (mon_e.chk_a)    chk("pulse_addr", {22'd0, core_A}, {22'd0, mon_e.a});
               if (mon_e.chk_di)   chk("pulse_di", {24'd0, core_DI}, {24'd0, mon_e.di});
               if (mon_e.chk_dout) chk("pulse_dout", {24'd0, bus_data_out}, {24'd0, mon_e.dout});
            end
         end
      end
      phi2_prev <= core_phi2;
   end

   // Drives one bus cycle; entered and left just after a rising clk edge.
   task automatic bus_cycle(input vec_t v);
      sb_q.push_back(mk_exp(v));
      pushed++;
      bus_rw = v.rw; bus_addr = v.addr; bus_cs1 = v.cs1; bus_rs0 = v.rs0;
      bus_data_in = v.din; core_DO = v.cdo; core_OE = v.coe;
      bus_phi2 = 1'b1;
      repeat (v.high) @(posedge clk);
      #1 bus_phi2 = 1'b0;
      repeat (v.low) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] out_vec();
      return {9'd0, core_phi2, core_we_n, core_A, core_CS1, core_RS0, core_DI, bus_data_out, bus_data_oe};
   endfunction

   localparam logic [31:0] RESET_OUTS = {9'd0, 1'b0, 1'b1, 10'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

   initial begin
      vec_t rv;
      // Stimulus table: write, short cycle, 10 back-to-back at clk/8, read with OE low.
      vecs[0] = '{rw:1'b0, addr:10'h3C5, cs1:1'b0, rs0:1'b1, din:8'h5A, cdo:8'hFF, coe:1'b1,
                  high:8, low:6, exp_we_n:1'b0, exp_a:10'h3C5, exp_cs1:1'b0, exp_rs0:1'b1,
                  exp_di:8'h5A, exp_dout:8'h00, exp_oe:1'b0, chk_a:1'b1, chk_di:1'b1, chk_dout:1'b0};
      vecs[1] = '{rw:1'b0, addr:10'h155, cs1:1'b1, rs0:1'b1, din:8'h33, cdo:8'hEE, coe:1'b1,
                  high:2, low:6, exp_we_n:1'b1, exp_a:10'h000, exp_cs1:1'b0, exp_rs0:1'b0,
                  exp_di:8'h00, exp_dout:8'h00, exp_oe:1'b0, chk_a:1'b0, chk_di:1'b0, chk_dout:1'b0};
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            vecs[2+i] = '{rw:1'b1, addr:10'h3C0, cs1:1'b1, rs0:1'b0, din:8'h00, cdo:8'(8'h10 + i),
                          coe:1'b1, high:4, low:4, exp_we_n:1'b1, exp_a:10'h3C0, exp_cs1:1'b1,
                          exp_rs0:1'b0, exp_di:8'h00, exp_dout:8'(8'h10 + i), exp_oe:1'b1,
                          chk_a:1'b1, chk_di:1'b0, chk_dout:1'b1};
         else
            vecs[2+i] = '{rw:1'b0, addr:10'h3C1, cs1:1'b1, rs0:1'b1, din:8'(8'hC0 + i), cdo:8'h99,
                          coe:1'b1, high:4, low:4, exp_we_n:1'b0, exp_a:10'h3C1, exp_cs1:1'b1,
                          exp_rs0:1'b1, exp_di:8'(8'hC0 + i), exp_dout:8'h00, exp_oe:1'b0,
                          chk_a:1'b1, chk_di:1'b1, chk_dout:1'b0};
      end
      vecs[12] = '{rw:1'b1, addr:10'h07E, cs1:1'b1, rs0:1'b1, din:8'h00, cdo:8'h6C, coe:1'b0,
                   high:8, low:6, exp_we_n:1'b1, exp_a:10'h07E, exp_cs1:1'b1, exp_rs0:1'b1,
                   exp_di:8'h00, exp_dout:8'h6C, exp_oe:1'b0, chk_a:1'b1, chk_di:1'b1, chk_dout:1'b1};
      // vecs[12] expects DI still holding the last back-to-back write value.
      vecs[12].exp_di = 8'hC9;

      rst = 1'b1; bus_phi2 = 1'b0; bus_rw = 1'b1; bus_addr = '0; bus_cs1 = 1'b0;
      bus_rs0 = 1'b0; bus_data_in = '0; core_DO = '0; core_OE = 1'b0;

      // Reset with PHI2 toggling
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 bus_phi2 = ~bus_phi2;
         @(negedge clk);
         chk("reset_outputs", out_vec(), RESET_OUTS);
      end
      rst = 1'b0; bus_phi2 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("post_reset_idle", out_vec(), RESET_OUTS);
      @(posedge clk); #1;

      // Timed read: latch 6 clk after the pin rise, data one clk later, oe 1 clk past the pulse.
      rv = '{rw:1'b1, addr:10'h123, cs1:1'b1, rs0:1'b0, din:8'h00, cdo:8'hA5, coe:1'b1,
             high:10, low:6, exp_we_n:1'b1, exp_a:10'h123, exp_cs1:1'b1, exp_rs0:1'b0,
             exp_di:8'h00, exp_dout:8'hA5, exp_oe:1'b1, chk_a:1'b1, chk_di:1'b1, chk_dout:1'b1};
      sb_q.push_back(mk_exp(rv)); pushed++;
      bus_rw = 1'b1; bus_addr = 10'h123; bus_cs1 = 1'b1; bus_rs0 = 1'b0;
      core_DO = 8'hA5; core_OE = 1'b1; bus_phi2 = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("read_addr_before_latch", {22'd0, core_A}, 32'h000);
      @(posedge clk); @(negedge clk);
      chk("read_addr_latched", {22'd0, core_A}, 32'h123);
      chk("read_cs1_latched", {31'd0, core_CS1}, 32'd1);
      chk("read_oe_before_data", {31'd0, bus_data_oe}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("read_dout", {24'd0, bus_data_out}, 32'hA5);
      chk("read_oe_on", {31'd0, bus_data_oe}, 32'd1);
      repeat (3) @(posedge clk);
      #1 bus_phi2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("read_pulse_time", {31'd0, core_phi2}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("read_pulse_end", {31'd0, core_phi2}, 32'd0);
      chk("read_oe_hold", {31'd0, bus_data_oe}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("read_oe_cleared", {31'd0, bus_data_oe}, 32'd0);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a read: no pulse for that cycle, even when PHI2 later falls.
      bus_addr = 10'h2AA; core_DO = 8'h77; core_OE = 1'b1; bus_rw = 1'b1; bus_phi2 = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("abort_oe_before_reset", {31'd0, bus_data_oe}, 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("abort_outputs_reset", out_vec(), RESET_OUTS);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus_phi2 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("abort_no_pulse", {31'd0, core_phi2}, 32'd0);
      @(posedge clk); #1;

      // Table-driven cycles
      for (int i = 0; i < 13; i++) begin
         bus_cycle(vecs[i]);
      end

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      chk("pulse_count", pulses, pushed);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_sampler.md
Name: bus_sampler

Overview:
- Upstream front end for the 6530 RRIOT core when it replaces a socketed part.
- Runs on a fast FPGA clock and oversamples the asynchronous 6502 socket pins (PHI2, R/W, A, D, CS1, RS0).
- Presents a clean, latched transaction to the core: address, direction, selects and write data, plus one core_phi2 pulse per bus cycle.
- Returns the core's read data onto the socket data bus with a bounded drive window.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on bus_phi2 before edge detection (min 2).
- SETTLE_CYCLES, 3, clk cycles after a detected PHI2 rise before address/control are latched (min 1).
- HOLD_CYCLES, 1, clk cycles bus_data_oe stays asserted after a detected PHI2 fall (min 0).

Ports:
- clk  in  1  system clock, at least 8x PHI2
- rst  in  1  synchronous reset, active-high
- bus_phi2  in  1  socket PHI2, asynchronous
- bus_rw  in  1  socket R/W, 1=read
- bus_addr  in  10  socket A[9:0]
- bus_cs1  in  1  socket CS1
- bus_rs0  in  1  socket RS0
- bus_data_in  in  8  socket D, input side
- bus_data_out  out  8  socket D, output side
- bus_data_oe  out  1  drive enable for socket D
- core_phi2  out  1  core clock, one clk-wide high pulse per bus cycle
- core_we_n  out  1  to core we_n
- core_A  out  10  to core A
- core_CS1  out  1  to core CS1
- core_RS0  out  1  to core RS0
- core_DI  out  8  to core DI
- core_DO  in  8  from core DO
- core_OE  in  1  from core OE

Behaviour:
- One clock domain, clk; all state updates on rising clk; rst synchronous, active-high.
- bus_phi2 passes through SYNC_STAGES flops to give phi2_s; phi2_d is phi2_s delayed one cycle.
- rise = phi2_s & ~phi2_d; fall = ~phi2_s & phi2_d.
- Other bus pins are sampled unsynchronised, only in the cycles named below; they are stable by then.
- Reset values: state IDLE, counter 0, core_phi2 0, core_we_n 1, core_A 0, core_CS1 0, core_RS0 0, core_DI 0, bus_data_out 0, bus_data_oe 0. Sync flops cleared.
- FSM states: IDLE, SETTLE, READ, WRITE, PULSE, HOLD.
- IDLE: on rise, go to SETTLE with counter=0.
- SETTLE:
  - Increment counter each cycle.
  - At counter==SETTLE_CYCLES-1, register bus_addr, bus_rw, bus_cs1 and bus_rs0 into core_A, core_we_n (=bus_rw), core_CS1 and core_RS0.
  - Next state is READ if bus_rw=1, else WRITE.
- READ:
  - Every cycle, bus_data_out<=core_DO and bus_data_oe<=core_OE, so data is valid one cycle after the address latch.
  - On fall, go to PULSE.
- WRITE:
  - bus_data_oe held 0.
  - On fall, core_DI<=bus_data_in, sampled at the fall-detect cycle; go to PULSE.
- PULSE:
  - core_phi2=1 for exactly this one cycle; core_A, selects, core_we_n and core_DI are held stable.
  - Then core_phi2 returns to 0 and the FSM goes to HOLD.
- HOLD:
  - bus_data_oe is kept for HOLD_CYCLES counted from PULSE entry; if HOLD_CYCLES=0 it is cleared on PULSE exit.
  - Afterwards, set bus_data_oe=0 and core_we_n=1 and go to IDLE.
- Short cycle (fall while in SETTLE):
  - The latch has not occurred; force core_CS1=0, core_RS0=0 and core_we_n=1 so the core sees no select.
  - Go to PULSE. The timer still ticks once; no RAM write or read-drive happens.
- Rise while in HOLD or PULSE: finish PULSE if active, clear bus_data_oe immediately, and enter SETTLE with counter=0. No bus cycle is lost.
- A rise seen in READ or WRITE is impossible (a fall comes first) and is ignored.
- Exactly one core_phi2 pulse occurs per detected fall; none are generated without a fall.
- Reset mid-cycle returns to IDLE with all outputs at reset values. The next pulse only follows a fresh rise then fall.
- bus_data_oe is never 1 while core_we_n=0.

Test Plan:
- Reset: assert rst for 3 clk with bus_phi2 toggling → every output at its reset value, core_phi2 stays 0.
- Read: RS0=0, CS1=1, rw=1, A=0x123, core_DO=0xA5, core_OE=1 → core_A=0x123 at 2+1+3 clk after the pin rise, bus_data_out=0xA5 and oe=1 next cycle, one core_phi2 pulse after the fall, oe clears 1 clk after the pulse.
- Write: RS0=1, CS1=0, rw=0, A=0x3C5, D=0x5A held across the fall → core_we_n=0, core_DI=0x5A during the single core_phi2 pulse, bus_data_oe never 1.
- Short cycle: PHI2 high for 2 clk only → exactly one core_phi2 pulse with core_CS1=0, core_RS0=0, core_we_n=1.
- Back-to-back: 10 cycles of PHI2 at clk/8 alternating read 0x3C0 and write 0x3C1 → 10 pulses, correct we_n/data per cycle, no oe overlap into a write.
- Reset mid-READ: assert rst while oe=1 → oe=0 and state IDLE next clk; no pulse emitted for the aborted cycle.
